// File: rtl/monty_reduce_u_pkg.sv
// Shared types for the Montgomery reducer: FSM state encoding, parameter bundle
// and result-latency helper.
package monty_reduce_u_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] logq;
        logic [15:0] logqh;
        logic [15:0] w;
    } monty_params_t;

    // Accept-to-first-valid latency in cycles: one per digit plus the DONE entry.
    function automatic int unsigned monty_latency(input monty_params_t p);
        return 32'(p.logq / p.w) + 32'd1;
    endfunction

endpackage

// File: rtl/monty_reduce_u_digit_mul.sv
// Combinational W x LOGQH multiplier: the only product in the datapath is m*qH.
module digit_mul_u #(
    parameter int unsigned W     = 8,
    parameter int unsigned LOGQH = 17
) (
    input  logic [W-1:0]       m_i,
    input  logic [LOGQH-1:0]   qh_i,
    output logic [W+LOGQH-1:0] prod_o
);

    localparam int unsigned PW = W + LOGQH;

    assign prod_o = PW'(m_i) * PW'(qh_i);

endmodule

// File: rtl/monty_reduce_u.sv
// Digit-serial Montgomery reduction for q = qH*2^R + 1: C = A*2^-LOGQ mod q, C < 2q.
// One W-bit digit is retired per RUN cycle; the final subtraction is left downstream.
module monty_reduce_u
    import monty_reduce_u_pkg::*;
#(
    parameter int unsigned LOGQ  = 64,
    parameter int unsigned LOGQH = 17,
    parameter int unsigned W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LOGQH-1:0]    qH,
    input  logic [2*LOGQ-1:0]   A,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOGQ:0]       C
);

    localparam int unsigned R   = LOGQ - LOGQH;
    localparam int unsigned AW  = 2*LOGQ + 1;
    localparam int unsigned PW  = W + LOGQH;
    localparam monty_params_t P = '{logq: 16'(LOGQ), logqh: 16'(LOGQH), w: 16'(W)};
    localparam int unsigned N   = monty_latency(P) - 1;
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;

    if (W == 0 || LOGQH >= LOGQ || W > R || (LOGQ % W) != 0) begin : g_bad_params
        $error("monty_reduce_u: illegal LOGQ/LOGQH/W combination");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [LOGQH-1:0] qh_q, qh_d;

    logic [W-1:0]    m_c;
    logic [PW-1:0]   prod_c;
    logic [AW-1:0]   sum_c;

    // m makes the low W bits of acc + m*q vanish since q == 1 mod 2^W.
    assign m_c = W'(0) - acc_q[W-1:0];

    digit_mul_u #(
        .W     (W),
        .LOGQH (LOGQH)
    ) u_digit_mul (
        .m_i    (m_c),
        .qh_i   (qh_q),
        .prod_o (prod_c)
    );

    assign sum_c = acc_q + AW'({prod_c, {R{1'b0}}}) + AW'(m_c);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        qh_d    = qh_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = AW'(A);
                    qh_d    = qH;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = sum_c >> W;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand storage is meaningful only after an accept, so it carries no reset.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        qh_q  <= qh_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign C         = acc_q[LOGQ:0];

endmodule

// File: tb/tb_monty_reduce_u.sv
// Directed and congruence-checked bench for monty_reduce_u with LOGQ=8, LOGQH=4, W=2.
module tb_monty_reduce_u;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  qH;
    logic [15:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  C;

    int checks   = 0;
    int failures = 0;

    monty_reduce_u #(
        .LOGQ  (8),
        .LOGQH (4),
        .W     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .qH        (qH),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one operand through with out_ready high; returns C and whether out_valid arrived.
    task automatic do_op(input logic [15:0] a, input logic [3:0] qh,
                         output logic [8:0] c, output logic ok);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin
            step;
            n++;
        end
        in_valid = 1'b1;
        A        = a;
        qH       = qh;
        step;
        in_valid = 1'b0;
        A        = 16'($urandom);
        qH       = 4'($urandom);
        n = 0;
        while (!out_valid && n < 30) begin
            step;
            n++;
        end
        ok = out_valid;
        c  = C;
        step;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; qH = '0;
        repeat (3) step;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        rst = 1'b1;
        step;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency;
        int first;
        int low_cnt;
        logic [8:0] c_seen;
        first = -1; low_cnt = 0; c_seen = '0;
        out_ready = 1'b1;
        in_valid = 1'b1; A = 16'd1; qH = 4'b1100;
        step;
        in_valid = 1'b0; A = 16'hBEEF;
        // Sample k=0 is the first cycle after the accept edge (cycle t+1).
        for (int k = 0; k < 10; k++) begin
            if (!in_ready) low_cnt++;
            if (out_valid && first < 0) begin
                first  = k;
                c_seen = C;
            end
            step;
        end
        checks++;
        if (first !== 4) begin
            failures++;
            $display("FAIL latency: first out_valid at sample %0d want 4", first);
        end
        checks++;
        if (low_cnt !== 5) begin
            failures++;
            $display("FAIL in_ready_low: %0d cycles want 5", low_cnt);
        end
        checks++;
        if (c_seen !== 9'd144) begin
            failures++;
            $display("FAIL c_a1: C=%0d want 144", c_seen);
        end
    endtask

    task automatic test_values;
        logic [15:0] av [3] = '{16'd256, 16'd0, 16'd49408};
        logic [8:0]  ev [3] = '{9'd1, 9'd0, 9'd193};
        logic [8:0]  c;
        logic        ok;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], 4'b1100, c, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL value_timeout: A=%0d out_valid=%b want 1", av[i], ok);
            end
            checks++;
            if (c !== ev[i]) begin
                failures++;
                $display("FAIL value: A=%0d C=%0d want %0d", av[i], c, ev[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int   n;
        logic stable;
        out_ready = 1'b0;
        in_valid = 1'b1; A = 16'd1; qH = 4'b1100;
        step;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            step;
            n++;
        end
        // A fresh request while stalled in DONE must be ignored.
        in_valid = 1'b1; A = 16'd256;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (out_valid !== 1'b1 || C !== 9'd144) stable = 1'b0;
            step;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL hold_stable: out_valid=%b C=%0d want 1 144 throughout", out_valid, C);
        end
        out_ready = 1'b1;
        step;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL handshake_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_reset_mid_run;
        logic [8:0] c;
        logic       ok;
        out_ready = 1'b1;
        in_valid = 1'b1; A = 16'd49408; qH = 4'b1100;
        step;
        in_valid = 1'b0;
        step;
        rst = 1'b0;
        step;
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        do_op(16'd256, 4'b1100, c, ok);
        checks++;
        if (!ok || c !== 9'd1) begin
            failures++;
            $display("FAIL after_abort: ok=%b C=%0d want 1 1", ok, c);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        logic [8:0] c1;
        logic [8:0] c2;
        int n;
        first = -1; second = -1; c1 = '0; c2 = '0;
        out_ready = 1'b1;
        in_valid = 1'b1; A = 16'd256; qH = 4'b1100;
        for (int k = 0; k < 20; k++) begin
            step;
            if (out_valid) begin
                if (first < 0) begin
                    first = k; c1 = C;
                end else if (second < 0) begin
                    second = k; c2 = C;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (first < 0 || second - first !== 6) begin
            failures++;
            $display("FAIL throughput: result spacing %0d want 6", second - first);
        end
        checks++;
        if (c1 !== 9'd1 || c2 !== 9'd1) begin
            failures++;
            $display("FAIL b2b_values: C=%0d,%0d want 1,1", c1, c2);
        end
        n = 0;
        while (!in_ready && n < 30) begin
            step;
            n++;
        end
    endtask

    task automatic test_random;
        logic [3:0]  qh;
        logic [15:0] a;
        logic [8:0]  c;
        logic        ok;
        int          q;
        for (int i = 0; i < 8; i++) begin
            qh = 4'($urandom_range(0, 15));
            q  = int'(qh) * 16 + 1;
            a  = 16'($urandom_range(0, q*q - 1));
            do_op(a, qh, c, ok);
            checks++;
            // C*2^8 == A (mod q) and C < 2q characterises C or C-q being A*2^-8 mod q.
            if (!ok || int'(c) >= 2*q || (int'(c) * 256) % q !== int'(a) % q) begin
                failures++;
                $display("FAIL random: q=%0d A=%0d C=%0d ok=%b want C*256==A mod q and C<2q",
                         q, a, c, ok);
            end
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_values;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/monty_reduce_u.md
MONTY_REDUCE_U -- requirements
Module: monty_reduce_u

Interface
REQ-001 Parameter LOGQ, default 64: modulus width in bits.
REQ-002 Parameter LOGQH, default 17: width of the modulus high part qH; q = qH*2^R + 1 with R = LOGQ-LOGQH.
REQ-003 Parameter W, default 8: reduction digit width; legal only if 1 <= W <= R and W divides LOGQ; N = LOGQ/W iterations.
REQ-004 Port clk  input  1: single clock; all state updates on posedge.
REQ-005 Port rst  input  1: synchronous, active-low reset.
REQ-006 Port in_valid  input  1: A and qH are valid.
REQ-007 Port in_ready  output  1: block can accept an operand.
REQ-008 Port qH  input  LOGQH: modulus high part, sampled on accept.
REQ-009 Port A  input  2*LOGQ: product to reduce, A < q^2.
REQ-010 Port out_valid  output  1: C is valid.
REQ-011 Port out_ready  input  1: downstream correction stage accepts C.
REQ-012 Port C  output  LOGQ+1: result, C ≡ A*2^(-LOGQ) mod q, 0 <= C < 2q; feeds the final conditional-subtraction stage unchanged.

Function
REQ-013 FSM states IDLE, RUN, DONE; exactly one active.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid=1 -> latch A into accumulator (2*LOGQ+1 bits), latch qH, clear iteration counter, go to RUN.
REQ-015 RUN: in_ready=0, out_valid=0; each cycle one iteration: m = (2^W - acc[W-1:0]) mod 2^W; acc = (acc + m*q) >> W; counter += 1.
REQ-016 m*q formed as ((m*qH) << R) + m; no general multiplier by q.
REQ-017 After the N-th iteration (counter = N-1 in RUN) go to DONE.
REQ-018 DONE: out_valid=1, C = acc[LOGQ:0], in_ready=0; C and out_valid held stable until out_ready=1.
REQ-019 DONE with out_ready=1 -> IDLE next cycle; no operand accepted in the same cycle.
REQ-020 Latency: accept at cycle t -> out_valid first high at cycle t+N+1; throughput one result per N+2 cycles when out_ready is tied high.
REQ-021 Low W bits of acc + m*q are zero every iteration; the discarded bits carry no information.
REQ-022 in_valid while not in IDLE is ignored; A and qH changes outside the accept cycle do not affect the result.
REQ-023 Accumulator never overflows 2*LOGQ+1 bits for A < q^2; A >= q^2 gives undefined C but the FSM still completes normally.
REQ-024 out_ready while not in DONE has no effect.

Reset
REQ-025 rst=0 at any posedge, including mid-RUN or in DONE: state IDLE, counter 0, out_valid 0, in_ready 1 on the following cycle; the in-flight operand is discarded.
REQ-026 Accumulator and latched qH carry no reset and are undefined until the first accept; C is don't-care while out_valid=0.

Structure
REQ-027 Shared header monty_reduce_u.svh holds the state enum typedef, a params struct {LOGQ, LOGQH, W} and a latency function returning N+1.
REQ-028 One sub-module, digit_mul_u, a combinational W x LOGQH multiplier producing m*qH.
REQ-029 Elaboration fails when W > R, W = 0 or LOGQ mod W != 0.

Verification (LOGQ=8, LOGQH=4, W=2, qH=4'b1100, so q=193, N=4)
REQ-030 A=1, out_ready=1 -> C=144 at accept+5; in_ready low for 5 cycles.
REQ-031 A=256 -> C=1; A=0 -> C=0.
REQ-032 A=49408 (193*256) -> C=193, which is equal to q and within [0,2q).
REQ-033 A=1, out_ready held 0 for 10 cycles -> C=144 and out_valid held stable throughout; handshake then returns to IDLE.
REQ-034 rst=0 during the 2nd RUN cycle -> IDLE; then A=256 -> C=1, with no residue from the aborted operand.
REQ-035 Random A < q^2 for random legal qH, compared against the reference model A*2^-8 mod q, with C or C-q matching and C < 2q.
